// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame FSM states and default frame geometry,
// common to the master and the LED slave side.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

  localparam int DATA_WIDTH_DEF = 8;  // bits per frame
  localparam int CLK_DIV_DEF    = 4;  // clk cycles per SCLK half-period

endpackage

// File: rtl/spi_master_if.sv
// Parallel request side plus serial pins of the SPI master.
// master: the spi_master itself; slave: the on-board logic / pin consumer.
interface spi_master_if #(
  parameter int DATA_WIDTH = spi_pkg::DATA_WIDTH_DEF
);
  logic                  start;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  busy;
  logic                  done;
  logic                  SCLK;
  logic                  MOSI;
  logic                  SS;

  modport master (
    input  start, data_in,
    output busy, done, SCLK, MOSI, SS
  );

  modport slave (
    output start, data_in,
    input  busy, done, SCLK, MOSI, SS
  );
endinterface

// File: rtl/spi_clk_tick.sv
// Half-period divider: one-cycle tick every CLK_DIV cycles while enabled.
// Clearing restarts the count so the first tick lands CLK_DIV cycles later.
module spi_clk_tick #(
  parameter int CLK_DIV = spi_pkg::CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise wrap at LAST while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // count register, synchronous clear on reset
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);
endmodule

// File: rtl/spi_master.sv
// Mode-0, LSB-first, transmit-only SPI master. Every pin is a flop output;
// the FSM only moves on divider ticks once a frame has been accepted.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CLK_DIV    = CLK_DIV_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);
  localparam int            BW       = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] ALL_BITS = BW'(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  ss_q, ss_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  accept, tick;

  assign accept = (state_q == IDLE) && bus.start;

  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q != IDLE),
    .clr_i (accept),
    .tick_o(tick)
  );

  // next state and next pin values; done is a single-cycle pulse
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ss_d    = ss_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        shift_d = bus.data_in;
        bcnt_d  = '0;
        mosi_d  = bus.data_in[0];
        ss_d    = 1'b0;
        sclk_d  = 1'b0;
        busy_d  = 1'b1;
        state_d = LEAD;
      end
      LEAD: if (tick) begin
        sclk_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (tick) begin
        if (bcnt_q == ALL_BITS) begin
          // final low half-period after the last fall has elapsed
          state_d = TRAIL;
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d  = 1'b0;
          shift_d = shift_q >> 1;
          bcnt_d  = bcnt_q + BW'(1);
          // keep the last bit on MOSI through the trailing period
          if (bcnt_q != LAST_BIT) mosi_d = shift_d[0];
        end
      end
      TRAIL: if (tick) begin
        ss_d    = 1'b1;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers; reset aborts any frame with no done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcnt_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.SCLK = sclk_q;
  assign bus.MOSI = mosi_q;
  assign bus.SS   = ss_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV 4 and 2), a slave-side
// monitor per instance that rebuilds each word from MOSI on SCLK rises and
// checks it against a scoreboard queue filled when stimulus is driven.
module tb_spi_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_if #(.DATA_WIDTH(8)) ifa ();
  spi_master_if #(.DATA_WIDTH(8)) ifb ();

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // slave-side monitor state, indexed by instance
  int         cyc = 0;
  logic       pss[2], psclk[2], pmosi[2];
  int         fall_c[2], lrise_c[2], rises[2], ssr_c[2], gap[2];
  logic [7:0] cap[2];

  task automatic mon(input int d, input int cd, input logic ss, input logic sclk,
                     input logic mosi, input logic done);
    logic [7:0] e;
    if (pss[d] && !ss) begin
      fall_c[d] = cyc;
      gap[d]    = cyc - ssr_c[d];
      rises[d]  = 0;
      cap[d]    = '0;
    end
    if (!ss && sclk && psclk[d]) chk("mosi_stable_high", mosi, pmosi[d]);
    if (!ss && sclk && !psclk[d]) begin
      if (rises[d] == 0) chk("first_rise_delay", cyc - fall_c[d], cd);
      else               chk("sclk_period", cyc - lrise_c[d], 2 * cd);
      if (rises[d] < 8) cap[d][rises[d]] = mosi;
      rises[d]++;
      lrise_c[d] = cyc;
    end
    if (!pss[d] && ss) begin
      ssr_c[d] = cyc;
      chk("done_at_ss_rise", done, 1);
      chk("rise_count", rises[d], 8);
      chk("frame_len", cyc - fall_c[d], 18 * cd);
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        chk("unexpected_frame", 1, 0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk("rx_word", cap[d], e);
      end
    end else if (done) begin
      chk("done_without_ss_rise", 1, 0);
    end
    pss[d]   = ss;
    psclk[d] = sclk;
    pmosi[d] = mosi;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        pss[d] = 1'b1; psclk[d] = 1'b0; pmosi[d] = 1'b0; rises[d] = 0;
      end
    end else begin
      mon(0, 4, ifa.SS, ifa.SCLK, ifa.MOSI, ifa.done);
      mon(1, 2, ifb.SS, ifb.SCLK, ifb.MOSI, ifb.done);
    end
  end

  // drive one word into instance A; returns at cycle 1 of the frame
  task automatic send_a(input logic [7:0] d);
    ifa.start = 1'b1; ifa.data_in = d; q0.push_back(d);
    @(negedge clk);
    ifa.start = 1'b0; ifa.data_in = ~d;
    chk("cycle1_ss_busy_mosi", {ifa.SS, ifa.busy, ifa.MOSI}, {2'b01, d[0]});
  endtask

  // wait (bounded) for done on A; n counts cycles since acceptance
  task automatic wait_done_a(input int n0, output int n);
    n = n0;
    while (!ifa.done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!ifa.done) chk("done_timeout", 0, 1);
  endtask

  task automatic count_done_a(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ifa.done) cnt++;
    end
  endtask

  int n, extra;

  initial begin
    ifa.start = 1'b1; ifa.data_in = 8'hFF;
    ifb.start = 1'b0; ifb.data_in = 8'h00;
    rst_n = 1'b0;
    // reset held with start high
    repeat (3) begin
      @(negedge clk);
      chk("rst_idle", {ifa.SS, ifa.SCLK, ifa.MOSI, ifa.busy, ifa.done}, 5'b10000);
    end
    rst_n = 1'b1; ifa.start = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_a", {ifa.SS, ifa.SCLK, ifa.MOSI, ifa.busy, ifa.done}, 5'b10000);
    chk("post_rst_idle_b", {ifb.SS, ifb.SCLK, ifb.MOSI, ifb.busy, ifb.done}, 5'b10000);

    // single frame
    send_a(8'hA5);
    wait_done_a(1, n);
    chk("done_cycle_a5", n, 73);
    chk("busy_in_done", ifa.busy, 0);
    @(negedge clk);
    chk("slave_6bit", cap[0][5:0], 6'b100101);
    repeat (3) @(negedge clk);

    // back-to-back with start held high
    ifa.start = 1'b1; ifa.data_in = 8'h3C; q0.push_back(8'h3C);
    @(negedge clk);
    ifa.data_in = 8'h00;
    wait_done_a(1, n);
    chk("done_cycle_3c", n, 73);
    ifa.data_in = 8'hC3; q0.push_back(8'hC3);
    @(negedge clk);
    ifa.start = 1'b0;
    chk("b2b_second_start", {ifa.SS, ifa.busy}, 2'b01);
    wait_done_a(1, n);
    chk("done_cycle_c3", n, 73);
    @(negedge clk);
    chk("ss_gap", gap[0], 1);
    repeat (3) @(negedge clk);

    // start while busy is ignored
    send_a(8'h00);
    repeat (19) @(negedge clk);
    ifa.start = 1'b1; ifa.data_in = 8'hFF;
    @(negedge clk);
    ifa.start = 1'b0;
    wait_done_a(21, n);
    chk("done_cycle_00", n, 73);
    count_done_a(100, extra);
    chk("no_extra_done", extra, 0);

    // reset mid-frame
    send_a(8'h77);
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_idle", {ifa.SS, ifa.SCLK, ifa.busy, ifa.done}, 4'b1000);
    void'(q0.pop_back());
    rst_n = 1'b1;
    count_done_a(100, extra);
    chk("no_done_after_abort", extra, 0);
    send_a(8'h5A);
    wait_done_a(1, n);
    chk("done_cycle_5a", n, 73);
    repeat (3) @(negedge clk);

    // CLK_DIV = 2 instance
    ifb.start = 1'b1; ifb.data_in = 8'h81; q1.push_back(8'h81);
    @(negedge clk);
    ifb.start = 1'b0; ifb.data_in = 8'h00;
    chk("b_cycle1", {ifb.SS, ifb.busy, ifb.MOSI}, 3'b011);
    n = 1;
    while (!ifb.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_cycle_b", n, 37);

    repeat (5) @(negedge clk);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end, expected finish");
    $fatal(1, "simulation time limit");
  end
endmodule
